// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder for 16-bit {rw, addr[6:0], data[7:0]} frames, oversampled in sys_clk.
// Small read/write register file plus a read-only WHOAMI register.
//
// state | meaning
// IDLE  | waiting for synchronised CS falling edge
// ADDR  | shifting in rw + address byte on rising SCLK
// DATA  | shifting in data byte, shifting out read data on falling SCLK
// DONE  | 16 bits received, further SCLK ignored, commit on CS rising
module spi_reg_responder #(
    parameter int         NUM_REGS     = 8,
    parameter logic [6:0] WHOAMI_ADDR  = 7'h78,
    parameter logic [7:0] WHOAMI_VALUE = 8'hA5
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic       o_wr_strobe,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_frame_done,
    output logic       o_frame_error
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Synchronisers are left unreset so they track the pins through reset;
    // a frame already underway at reset release then shows no CS falling edge.
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge i_clock) begin
        sclk_sync <= {sclk_sync[1:0], i_sclk};
        cs_sync   <= {cs_sync[1:0], i_cs_n};
        mosi_sync <= {mosi_sync[0], i_mosi};
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];

    logic [7:0] regs [NUM_REGS];
    logic [3:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_nxt;
    logic [7:0] miso_sr;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] rd_data;
    logic       addr_mapped;

    assign shift_nxt   = {shift_in[6:0], mosi_sync[1]};
    assign addr_mapped = int'(addr_q) < NUM_REGS;

    always_comb begin
        rd_data = 8'h00;
        if (int'(shift_nxt[6:0]) < NUM_REGS) begin
            rd_data = regs[shift_nxt[AW-1:0]];
        end else if (shift_nxt[6:0] == WHOAMI_ADDR) begin
            rd_data = WHOAMI_VALUE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_ADDR;
            ST_ADDR: begin
                if (cs_rise)                             state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt == 4'd7)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)                             state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt == 4'd15)  state_d = ST_DONE;
            end
            ST_DONE: if (cs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bit_cnt       <= '0;
            shift_in      <= '0;
            miso_sr       <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            o_miso        <= 1'b0;
            o_miso_oe     <= 1'b0;
            o_wr_strobe   <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_done  <= 1'b0;
            o_frame_error <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            o_miso_oe     <= ~cs_sync[1];
            o_wr_strobe   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_error <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    o_miso <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        shift_in <= '0;
                        miso_sr  <= '0;
                    end
                end
                ST_ADDR: begin
                    o_miso <= 1'b0;
                    if (cs_rise) begin
                        o_frame_error <= 1'b1;
                    end else if (sclk_rise) begin
                        shift_in <= shift_nxt;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_q    <= shift_nxt[7];
                            addr_q  <= shift_nxt[6:0];
                            miso_sr <= shift_nxt[7] ? rd_data : 8'h00;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise) begin
                        o_frame_error <= 1'b1;
                        o_miso        <= 1'b0;
                    end else if (sclk_fall) begin
                        o_miso  <= miso_sr[7];
                        miso_sr <= {miso_sr[6:0], 1'b0};
                    end else if (sclk_rise) begin
                        shift_in <= shift_nxt;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            o_miso <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    o_miso <= 1'b0;
                    if (cs_rise) begin
                        o_frame_done <= 1'b1;
                        if (!rw_q && addr_mapped) begin
                            regs[addr_q[AW-1:0]] <= shift_in;
                            o_wr_strobe          <= 1'b1;
                            o_wr_addr            <= addr_q;
                            o_wr_data            <= shift_in;
                        end
                    end
                end
                default: o_miso <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: a bit-banged SPI master drives mode-0 frames
// at sys_clk/16 and compares MISO bytes and output pulses with hand-computed values.
module tb_spi_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_error;

    int vec_cnt = 0;
    int err_cnt = 0;

    int         n_strobe = 0;
    int         n_done = 0;
    int         n_err = 0;
    logic [6:0] last_addr = '0;
    logic [7:0] last_data = '0;

    logic [15:0] rx;
    logic        oe_mid;

    spi_reg_responder #(
        .NUM_REGS    (8),
        .WHOAMI_ADDR (7'h78),
        .WHOAMI_VALUE(8'hA5)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_sclk       (sclk),
        .i_cs_n       (cs_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe),
        .o_wr_strobe  (wr_strobe),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_frame_done (frame_done),
        .o_frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe) begin
            n_strobe  <= n_strobe + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (frame_done)  n_done <= n_done + 1;
        if (frame_error) n_err  <= n_err + 1;
    end

    // word[nbits-1] goes out first; rx collects MISO sampled just before each of the first 16 rising SCLK edges
    task automatic spi_xfer(input int nbits, input logic [31:0] word, input bit end_cs,
                            input int gap, output logic [15:0] rx_o, output logic oe_o);
        rx_o = '0;
        oe_o = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[nbits-1-i];
            repeat (8) @(negedge clk);
            if (i < 16) rx_o = {rx_o[14:0], miso};
            if (i == 0) oe_o = miso_oe;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        if (end_cs) begin
            cs_n = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if ({miso, miso_oe, wr_strobe, frame_done, frame_error} != 5'b0 ||
                wr_addr != 7'h00 || wr_data != 8'h00) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL reset_outputs: %0d cycles with nonzero outputs, required 0", bad);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vec_cnt++;
        if ({miso, miso_oe, wr_strobe, frame_done, frame_error} !== 5'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: outputs %b, required 00000",
                     {miso, miso_oe, wr_strobe, frame_done, frame_error});
        end
    endtask

    task automatic test_read_whoami();
        int s0, d0;
        s0 = n_strobe;
        d0 = n_done;
        spi_xfer(16, 32'h0000_F800, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h00A5) begin
            err_cnt++;
            $display("FAIL whoami_read: got %h, required 00a5", rx);
        end
        vec_cnt++;
        if (oe_mid !== 1'b1) begin
            err_cnt++;
            $display("FAIL oe_in_frame: got %b, required 1", oe_mid);
        end
        vec_cnt++;
        if (miso_oe !== 1'b0) begin
            err_cnt++;
            $display("FAIL oe_after_frame: got %b, required 0", miso_oe);
        end
        vec_cnt++;
        if (n_done - d0 !== 1 || n_strobe - s0 !== 0) begin
            err_cnt++;
            $display("FAIL whoami_pulses: done %0d strobe %0d, required 1 0", n_done - d0, n_strobe - s0);
        end
    endtask

    task automatic test_write_read();
        int s0, d0;
        s0 = n_strobe;
        d0 = n_done;
        spi_xfer(16, 32'h0000_035C, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (n_strobe - s0 !== 1 || last_addr !== 7'h03 || last_data !== 8'h5C) begin
            err_cnt++;
            $display("FAIL write_strobe: count %0d addr %h data %h, required 1 03 5c",
                     n_strobe - s0, last_addr, last_data);
        end
        vec_cnt++;
        if (rx !== 16'h0000) begin
            err_cnt++;
            $display("FAIL write_miso: got %h, required 0000", rx);
        end
        spi_xfer(16, 32'h0000_8300, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h005C) begin
            err_cnt++;
            $display("FAIL readback_reg3: got %h, required 005c", rx);
        end
        vec_cnt++;
        if (n_done - d0 !== 2 || n_strobe - s0 !== 1) begin
            err_cnt++;
            $display("FAIL write_read_pulses: done %0d strobe %0d, required 2 1", n_done - d0, n_strobe - s0);
        end
    endtask

    task automatic test_unmapped();
        int s0, d0;
        s0 = n_strobe;
        d0 = n_done;
        spi_xfer(16, 32'h0000_7811, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (n_strobe - s0 !== 0 || n_done - d0 !== 1) begin
            err_cnt++;
            $display("FAIL whoami_write: strobe %0d done %0d, required 0 1", n_strobe - s0, n_done - d0);
        end
        spi_xfer(16, 32'h0000_F800, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h00A5) begin
            err_cnt++;
            $display("FAIL whoami_after_write: got %h, required 00a5", rx);
        end
        spi_xfer(16, 32'h0000_9000, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h0000) begin
            err_cnt++;
            $display("FAIL unmapped_read: got %h, required 0000", rx);
        end
    endtask

    task automatic test_abort();
        int s0, d0, e0;
        s0 = n_strobe;
        d0 = n_done;
        e0 = n_err;
        spi_xfer(11, 32'h0000_05FF >> 5, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (n_err - e0 !== 1 || n_done - d0 !== 0 || n_strobe - s0 !== 0) begin
            err_cnt++;
            $display("FAIL abort_pulses: error %0d done %0d strobe %0d, required 1 0 0",
                     n_err - e0, n_done - d0, n_strobe - s0);
        end
        spi_xfer(16, 32'h0000_8500, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h0000 || n_done - d0 !== 1) begin
            err_cnt++;
            $display("FAIL after_abort_read: got %h done %0d, required 0000 1", rx, n_done - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0, d0, e0, bad;
        spi_xfer(16, 32'h0000_027E, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (last_addr !== 7'h02 || last_data !== 8'h7E) begin
            err_cnt++;
            $display("FAIL prewrite_reg2: addr %h data %h, required 02 7e", last_addr, last_data);
        end
        s0 = n_strobe;
        d0 = n_done;
        e0 = n_err;
        spi_xfer(6, 32'h0000_8200 >> 10, 1'b0, 0, rx, oe_mid);
        bad = 0;
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if ({miso, miso_oe, wr_strobe, frame_done, frame_error} != 5'b0) bad++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({miso, wr_strobe, frame_done, frame_error} != 4'b0) bad++;
        end
        cs_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if ({miso, wr_strobe, frame_done, frame_error} != 4'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL reset_mid_frame_quiet: %0d cycles with activity, required 0", bad);
        end
        vec_cnt++;
        if (n_strobe - s0 !== 0 || n_done - d0 !== 0 || n_err - e0 !== 0) begin
            err_cnt++;
            $display("FAIL reset_mid_frame_pulses: strobe %0d done %0d error %0d, required 0 0 0",
                     n_strobe - s0, n_done - d0, n_err - e0);
        end
        spi_xfer(16, 32'h0000_8200, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (rx !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reg2_after_reset: got %h, required 0000", rx);
        end
    endtask

    task automatic test_back_to_back();
        int s0, d0, e0;
        s0 = n_strobe;
        d0 = n_done;
        e0 = n_err;
        spi_xfer(20, {12'h000, 16'h0166, 4'hF}, 1'b1, 4, rx, oe_mid);
        spi_xfer(16, 32'h0000_8100, 1'b1, 8, rx, oe_mid);
        vec_cnt++;
        if (n_strobe - s0 !== 1 || last_addr !== 7'h01 || last_data !== 8'h66) begin
            err_cnt++;
            $display("FAIL overlong_strobe: count %0d addr %h data %h, required 1 01 66",
                     n_strobe - s0, last_addr, last_data);
        end
        vec_cnt++;
        if (rx !== 16'h0066) begin
            err_cnt++;
            $display("FAIL back_to_back_read: got %h, required 0066", rx);
        end
        vec_cnt++;
        if (n_done - d0 !== 2 || n_err - e0 !== 0) begin
            err_cnt++;
            $display("FAIL back_to_back_pulses: done %0d error %0d, required 2 0", n_done - d0, n_err - e0);
        end
    endtask

    initial begin
        test_reset();
        test_read_whoami();
        test_write_read();
        test_unmapped();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
